// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
// Captures the header byte, parks the byte that arrives while the selected
// FIFO is full, and accumulates running XOR parity over header + payload.
// The received parity byte is compared against that running parity once it
// has been forwarded, and a mismatch raises err.
module router_reg #(
    parameter int         DATA_WIDTH   = 8,
    parameter logic [1:0] INVALID_ADDR = 2'b11
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  rst_int_reg,
    input  logic                  detect_add,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  lfd_state,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] dout_reg,        dout_next;
    logic [DATA_WIDTH-1:0] header_byte_reg, header_byte_next;
    logic [DATA_WIDTH-1:0] full_byte_reg,   full_byte_next;
    logic [DATA_WIDTH-1:0] int_parity_reg,  int_parity_next;
    logic [DATA_WIDTH-1:0] pkt_parity_reg,  pkt_parity_next;
    logic                  parity_done_reg, parity_done_next;
    logic                  low_pkt_reg,     low_pkt_next;
    logic                  err_reg,         err_next;

    logic header_ok;
    logic parity_set;

    // A header is only accepted when it addresses a real output port.
    assign header_ok = detect_add & pkt_valid & (data_in[1:0] != INVALID_ADDR);

    // Parity byte has reached the FIFO either directly from LOAD_DATA or,
    // when it arrived while full, from the LOAD_AFTER_FULL replay.
    assign parity_set = (ld_state & ~fifo_full & ~pkt_valid) |
                        (laf_state & low_pkt_reg & ~parity_done_reg);

    // Byte steering: header capture, header replay, payload, full parking, full replay.
    always_comb begin
        dout_next        = dout_reg;
        header_byte_next = header_byte_reg;
        full_byte_next   = full_byte_reg;
        if (header_ok) begin
            header_byte_next = data_in;
        end else if (lfd_state) begin
            dout_next = header_byte_reg;
        end else if (ld_state && !fifo_full) begin
            dout_next = data_in;
        end else if (ld_state && fifo_full) begin
            full_byte_next = data_in;
        end else if (laf_state) begin
            dout_next = full_byte_reg;
        end
    end

    // Running parity over header and payload; received parity byte is latched separately.
    always_comb begin
        int_parity_next = int_parity_reg;
        pkt_parity_next = pkt_parity_reg;
        if (detect_add) begin
            int_parity_next = '0;
        end else if (lfd_state) begin
            int_parity_next = int_parity_reg ^ header_byte_reg;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity_next = int_parity_reg ^ data_in;
        end
        if (ld_state && !pkt_valid) begin
            pkt_parity_next = data_in;
        end else if (detect_add) begin
            pkt_parity_next = '0;
        end
    end

    // Status flags back to the FSM; a new packet (detect_add) clears before any set.
    always_comb begin
        parity_done_next = parity_done_reg;
        low_pkt_next     = low_pkt_reg;
        err_next         = err_reg;
        if (detect_add) begin
            parity_done_next = 1'b0;
        end else if (parity_set) begin
            parity_done_next = 1'b1;
        end
        if (rst_int_reg) begin
            low_pkt_next = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_next = 1'b1;
        end
        // Uses the registered parity_done, so err lands one cycle after it.
        if (detect_add) begin
            err_next = 1'b0;
        end else if (parity_done_reg && (int_parity_reg != pkt_parity_reg)) begin
            err_next = 1'b1;
        end
    end

    // State registers; reset clears every byte so no partial packet survives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout_reg        <= '0;
            header_byte_reg <= '0;
            full_byte_reg   <= '0;
            int_parity_reg  <= '0;
            pkt_parity_reg  <= '0;
            parity_done_reg <= 1'b0;
            low_pkt_reg     <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            dout_reg        <= dout_next;
            header_byte_reg <= header_byte_next;
            full_byte_reg   <= full_byte_next;
            int_parity_reg  <= int_parity_next;
            pkt_parity_reg  <= pkt_parity_next;
            parity_done_reg <= parity_done_next;
            low_pkt_reg     <= low_pkt_next;
            err_reg         <= err_next;
        end
    end

    assign dout             = dout_reg;
    assign parity_done      = parity_done_reg;
    assign low_packet_valid = low_pkt_reg;
    assign err              = err_reg;

endmodule
